// File: rtl/l2_tcdm_pkg.sv
// Shared types and constants for the L2 TCDM bank controller.
//   l2_state_e   : controller state (CLEAR = zero-fill sweep, READY = normal access)
//   L2_ERR_RDATA : read data returned with an error response
//   l2_idx_w()   : width of an index selecting one of n items (at least 1 bit)
package l2_tcdm_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } l2_state_e;

   localparam logic [31:0] L2_ERR_RDATA = 32'hBADA_CCE5;

   function automatic int unsigned l2_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/l2_tcdm_addr_dec.sv
// Combinational decode of a TCDM byte address into a word-interleaved
// bank index and row address.
//   add_i  : request byte address
//   bank_o : bank index (low word-offset bits)
//   row_o  : row inside the bank
//   oor_o  : address below BASE_ADDR or beyond the last word of the last bank
module l2_tcdm_addr_dec
   import l2_tcdm_pkg::*;
#(
   parameter int unsigned NB_BANKS  = 4,
   parameter int unsigned BANK_SIZE = 32768,
   parameter logic [31:0] BASE_ADDR = 32'h1C00_0000
) (
   input  logic [31:0]                        add_i,
   output logic [l2_idx_w(NB_BANKS)-1:0]      bank_o,
   output logic [l2_idx_w(BANK_SIZE)-1:0]     row_o,
   output logic                               oor_o
);

   localparam int unsigned BW = l2_idx_w(NB_BANKS);
   localparam int unsigned RW = l2_idx_w(BANK_SIZE);
   // Size of the whole region in bytes, kept in 33 bits so the compare
   // cannot overflow for the largest legal configuration.
   localparam logic [32:0] LIMIT_B = 33'(NB_BANKS) * 33'(BANK_SIZE) * 33'd4;

   logic [31:0] w_diff;

   assign w_diff = add_i - BASE_ADDR;

   // Comparing the byte difference against the byte size is equivalent to
   // comparing the word offset against the word count, since the base is
   // word aligned; a wrapped subtraction is caught by the explicit compare.
   assign oor_o  = (add_i < BASE_ADDR) || ({1'b0, w_diff} >= LIMIT_B);
   assign bank_o = w_diff[BW+1:2];
   assign row_o  = w_diff[BW+RW+1:BW+2];

endmodule

// File: rtl/l2_tcdm_bank_ctrl.sv
// TCDM slave in front of NB_BANKS single-port SRAM macros, word interleaved.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   req_i .. wdata_i    : TCDM request (wen_i = 1 read, 0 write)
//   gnt_o               : grant, same cycle as request when READY
//   r_valid_o/r_rdata_o/r_opc_o : response one cycle after grant
//   busy_o              : post-reset zero-fill in progress
//   bank_*_o            : shared SRAM control; bank_csn_o is per bank
//   bank_rdata_i        : per-bank read data, valid the cycle after a read
module l2_tcdm_bank_ctrl
   import l2_tcdm_pkg::*;
#(
   parameter int unsigned NB_BANKS       = 4,
   parameter int unsigned BANK_SIZE      = 32768,
   parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              req_i,
   input  logic [31:0]                       add_i,
   input  logic                              wen_i,
   input  logic [3:0]                        be_i,
   input  logic [31:0]                       wdata_i,
   output logic                              gnt_o,
   output logic                              r_valid_o,
   output logic [31:0]                       r_rdata_o,
   output logic                              r_opc_o,
   output logic                              busy_o,
   output logic [NB_BANKS-1:0]               bank_csn_o,
   output logic                              bank_wen_o,
   output logic [l2_idx_w(BANK_SIZE)-1:0]    bank_add_o,
   output logic [3:0]                        bank_be_o,
   output logic [31:0]                       bank_wdata_o,
   input  logic [NB_BANKS*32-1:0]            bank_rdata_i
);

   localparam int unsigned BW = l2_idx_w(NB_BANKS);
   localparam int unsigned RW = l2_idx_w(BANK_SIZE);

   l2_state_e    r_state;
   logic [RW-1:0] r_cnt;
   logic          r_vld;
   logic          r_err;
   logic          r_rd;
   logic [BW-1:0] r_bank;

   logic [BW-1:0] w_bank;
   logic [RW-1:0] w_row;
   logic          w_oor;
   logic          w_gnt;
   logic [31:0]   w_bank_rdata [NB_BANKS];

   l2_tcdm_addr_dec #(
      .NB_BANKS  (NB_BANKS),
      .BANK_SIZE (BANK_SIZE),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr_dec (
      .add_i  (add_i),
      .bank_o (w_bank),
      .row_o  (w_row),
      .oor_o  (w_oor)
   );

   for (genvar g = 0; g < NB_BANKS; g++) begin : g_rdata
      assign w_bank_rdata[g] = bank_rdata_i[g*32 +: 32];
   end

   // Request / bank side is combinational. Gating with rst_ni makes every
   // output show its reset value for as long as reset is held.
   assign w_gnt  = rst_ni && (r_state == READY) && req_i;
   assign gnt_o  = w_gnt;
   assign busy_o = (r_state == CLEAR);

   always_comb begin
      bank_csn_o   = '1;
      bank_wen_o   = 1'b1;
      bank_add_o   = '0;
      bank_be_o    = 4'h0;
      bank_wdata_o = 32'h0;
      if (rst_ni && (r_state == CLEAR)) begin
         bank_csn_o = '0;
         bank_wen_o = 1'b0;
         bank_add_o = r_cnt;
         bank_be_o  = 4'hF;
      end else if (w_gnt && !w_oor) begin
         bank_csn_o[w_bank] = 1'b0;
         bank_wen_o         = wen_i;
         bank_add_o         = w_row;
         bank_be_o          = be_i;
         bank_wdata_o       = wdata_i;
      end
   end

   // FSM, clear row counter and response stage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= CLEAR_ON_RESET ? CLEAR : READY;
         r_cnt   <= '0;
         r_vld   <= 1'b0;
         r_err   <= 1'b0;
         r_rd    <= 1'b0;
         r_bank  <= '0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_vld <= 1'b0;
               r_cnt <= r_cnt + RW'(1);
               if (r_cnt == RW'(BANK_SIZE - 1)) begin
                  r_state <= READY;
               end
            end
            READY: begin
               r_vld <= req_i;
               if (req_i) begin
                  r_err  <= w_oor;
                  r_rd   <= wen_i;
                  r_bank <= w_bank;
               end
            end
         endcase
      end
   end

   assign r_valid_o = r_vld;
   assign r_opc_o   = r_vld && r_err;

   always_comb begin
      r_rdata_o = 32'h0;
      if (r_vld) begin
         if (r_err) begin
            r_rdata_o = L2_ERR_RDATA;
         end else if (r_rd) begin
            r_rdata_o = w_bank_rdata[r_bank];
         end
      end
   end

endmodule

// File: tb/tb_l2_tcdm_bank_ctrl.sv
// Self-checking bench for l2_tcdm_bank_ctrl (4 banks x 16 words).
// A behavioural SRAM model sits on the bank port; a flat word array of the
// whole L2 region serves as the reference for every response.
module tb_l2_tcdm_bank_ctrl;

   localparam int unsigned NB   = 4;
   localparam int unsigned BS   = 16;
   localparam logic [31:0] BASE = 32'h1C00_0000;
   localparam logic [31:0] ERRD = 32'hBADACCE5;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          req_i;
   logic [31:0]   add_i;
   logic          wen_i;
   logic [3:0]    be_i;
   logic [31:0]   wdata_i;
   logic          gnt_o;
   logic          r_valid_o;
   logic [31:0]   r_rdata_o;
   logic          r_opc_o;
   logic          busy_o;
   logic [NB-1:0] bank_csn_o;
   logic          bank_wen_o;
   logic [3:0]    bank_add_o;
   logic [3:0]    bank_be_o;
   logic [31:0]   bank_wdata_o;
   logic [NB*32-1:0] bank_rdata_i;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] ref_mem [NB*BS];
   logic        pend_vld;
   logic        pend_err;
   logic [31:0] pend_data;

   logic        junk_en;
   logic [31:0] bmem [NB][BS];

   always #5 clk_i = ~clk_i;

   l2_tcdm_bank_ctrl #(
      .NB_BANKS       (NB),
      .BANK_SIZE      (BS),
      .BASE_ADDR      (BASE),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (req_i),
      .add_i        (add_i),
      .wen_i        (wen_i),
      .be_i         (be_i),
      .wdata_i      (wdata_i),
      .gnt_o        (gnt_o),
      .r_valid_o    (r_valid_o),
      .r_rdata_o    (r_rdata_o),
      .r_opc_o      (r_opc_o),
      .busy_o       (busy_o),
      .bank_csn_o   (bank_csn_o),
      .bank_wen_o   (bank_wen_o),
      .bank_add_o   (bank_add_o),
      .bank_be_o    (bank_be_o),
      .bank_wdata_o (bank_wdata_o),
      .bank_rdata_i (bank_rdata_i)
   );

   // Single-port SRAM macros: byte-masked write, registered read.
   always @(posedge clk_i) begin
      for (int b = 0; b < NB; b++) begin
         if (junk_en) begin
            for (int r = 0; r < BS; r++) bmem[b][r] <= $urandom;
         end else if (!bank_csn_o[b]) begin
            if (!bank_wen_o) begin
               for (int k = 0; k < 4; k++)
                  if (bank_be_o[k]) bmem[b][bank_add_o][8*k +: 8] <= bank_wdata_o[8*k +: 8];
            end else begin
               bank_rdata_i[32*b +: 32] <= bmem[b][bank_add_o];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at t=%0t", tag, act, exp, $time);
      end
   endtask

   // One bus cycle: drive, check at the falling edge, update the reference.
   task automatic step(input logic req, input logic wen, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
      longint unsigned a, off;
      bit inr;
      int b, r;
      logic [3:0] ecsn;
      req_i = req; wen_i = wen; add_i = addr; be_i = be; wdata_i = wd;
      @(negedge clk_i);
      chk("busy", 32'(busy_o), 32'd0);
      chk("r_valid", 32'(r_valid_o), 32'(pend_vld));
      if (pend_vld) begin
         chk("r_opc", 32'(r_opc_o), 32'(pend_err));
         chk("r_rdata", r_rdata_o, pend_data);
      end
      chk("gnt", 32'(gnt_o), 32'(req));
      a   = longint'(addr);
      inr = (a >= longint'(BASE)) && (((a - longint'(BASE)) / 4) < NB*BS);
      off = inr ? (a - longint'(BASE)) / 4 : 0;
      if (req && inr) begin
         b    = int'(off % NB);
         r    = int'(off / NB);
         ecsn = 4'hF;
         ecsn[b] = 1'b0;
         chk("csn", 32'(bank_csn_o), 32'(ecsn));
         chk("bank_wen", 32'(bank_wen_o), 32'(wen));
         chk("bank_add", 32'(bank_add_o), 32'(r));
         chk("bank_be", 32'(bank_be_o), 32'(be));
         chk("bank_wdata", bank_wdata_o, wd);
      end else begin
         chk("csn_none", 32'(bank_csn_o), 32'hF);
         if (!req) begin
            chk("idle_wen", 32'(bank_wen_o), 32'd1);
            chk("idle_add", 32'(bank_add_o), 32'd0);
            chk("idle_be", 32'(bank_be_o), 32'd0);
            chk("idle_wdata", bank_wdata_o, 32'd0);
         end
      end
      pend_vld = req;
      pend_err = !inr;
      pend_data = 32'd0;
      if (req) begin
         if (!inr) pend_data = ERRD;
         else if (wen) pend_data = ref_mem[off];
         else
            for (int k = 0; k < 4; k++)
               if (be[k]) ref_mem[off][8*k +: 8] = wd[8*k +: 8];
      end
      @(posedge clk_i); #1;
   endtask

   // Zero-fill sweep after reset release; the reference becomes all zero.
   task automatic run_clear(input logic hold_req);
      req_i = hold_req; wen_i = 1'b1; add_i = BASE + 32'h10; be_i = 4'h0; wdata_i = 32'h0;
      for (int i = 0; i < BS; i++) begin
         @(negedge clk_i);
         chk("clr_busy", 32'(busy_o), 32'd1);
         chk("clr_gnt", 32'(gnt_o), 32'd0);
         chk("clr_rvalid", 32'(r_valid_o), 32'd0);
         chk("clr_csn", 32'(bank_csn_o), 32'd0);
         chk("clr_wen", 32'(bank_wen_o), 32'd0);
         chk("clr_add", 32'(bank_add_o), 32'(i));
         chk("clr_be", 32'(bank_be_o), 32'hF);
         chk("clr_wdata", bank_wdata_o, 32'd0);
         @(posedge clk_i); #1;
      end
      for (int k = 0; k < NB*BS; k++) ref_mem[k] = 32'd0;
      pend_vld = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_gnt"}, 32'(gnt_o), 32'd0);
      chk({tag, "_rvalid"}, 32'(r_valid_o), 32'd0);
      chk({tag, "_rdata"}, r_rdata_o, 32'd0);
      chk({tag, "_ropc"}, 32'(r_opc_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd1);
      chk({tag, "_csn"}, 32'(bank_csn_o), 32'hF);
      chk({tag, "_wen"}, 32'(bank_wen_o), 32'd1);
   endtask

   task automatic random_steps(input int n);
      logic [31:0] addr;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 9))
            0:       addr = BASE - 32'(4 * $urandom_range(1, 8));
            1:       addr = BASE + 32'(NB*BS*4) + 32'(4 * $urandom_range(0, 8));
            2:       addr = $urandom;
            default: addr = BASE + 32'(4 * $urandom_range(0, NB*BS-1)) + 32'($urandom_range(0, 3));
         endcase
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), addr, 4'($urandom), $urandom);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_ni = 1'b0; req_i = 1'b0; add_i = '0; wen_i = 1'b1; be_i = '0; wdata_i = '0;
      pend_vld = 1'b0; pend_err = 1'b0; pend_data = '0;
      junk_en = 1'b1;
      for (int k = 0; k < NB*BS; k++) ref_mem[k] = 32'hFFFF_FFFF;
      @(negedge clk_i);
      check_reset_vals("rst");
      @(posedge clk_i); #1;
      junk_en = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // Clear with a request held, granted in the first READY cycle.
      run_clear(1'b1);
      step(1'b1, 1'b1, BASE + 32'h10, 4'h0, 32'h0);

      // Full write, read back, partial byte write, read back.
      step(1'b1, 1'b0, 32'h1C00_0008, 4'hF, 32'hDEAD_BEEF);
      step(1'b1, 1'b1, 32'h1C00_0008, 4'h0, 32'h0);
      step(1'b1, 1'b0, 32'h1C00_0008, 4'b0001, 32'h0000_00AA);
      step(1'b1, 1'b1, 32'h1C00_000B, 4'h0, 32'h0);
      step(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);

      // Back-to-back bank-1 traffic and an unwritten location.
      step(1'b1, 1'b0, 32'h1C00_0004, 4'hF, 32'h1111_2222);
      step(1'b1, 1'b0, 32'h1C00_0014, 4'hF, 32'h3333_4444);
      step(1'b1, 1'b1, 32'h1C00_0004, 4'h0, 32'h0);
      step(1'b1, 1'b1, 32'h1C00_0014, 4'h0, 32'h0);
      step(1'b1, 1'b1, 32'h1C00_0024, 4'h0, 32'h0);
      step(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);

      // Out-of-range reads and write.
      step(1'b1, 1'b1, 32'h1C00_0100, 4'h0, 32'h0);
      step(1'b1, 1'b1, 32'h1BFF_FFFC, 4'h0, 32'h0);
      step(1'b1, 1'b0, 32'h1C00_0100, 4'hF, 32'h5555_5555);
      step(1'b1, 1'b1, 32'h1C00_00FC, 4'h0, 32'h0);
      step(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);

      random_steps(400);
      step(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);

      // Reset right after a read grant drops the pending response.
      step(1'b1, 1'b1, 32'h1C00_0008, 4'h0, 32'h0);
      rst_ni = 1'b0; req_i = 1'b0;
      #1;
      check_reset_vals("midrst");
      pend_vld = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      run_clear(1'b0);
      for (int k = 0; k < NB*BS; k += 5) step(1'b1, 1'b1, BASE + 32'(4*k), 4'h0, 32'h0);
      random_steps(200);
      step(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
